// File: rtl/ac_motor_spwm.sv
// Three-phase sinusoidal PWM: triangle carrier, regularly-sampled sine references, comparators.
// Optional complementary gates with dead time when AC_MOTOR_DEAD_TIME_EN is defined.
module ac_motor_spwm #(
  parameter int unsigned TRI_STEP = 2048,
  parameter int unsigned TRI_MAX  = 4194304,
  parameter int unsigned PHASE_W  = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic        [11:0] frequency,
  input  logic        [11:0] amplitude,
`ifdef AC_MOTOR_DEAD_TIME_EN
  input  logic        [10:0] dead_time,
  output logic               out1_n,
  output logic               out2_n,
  output logic               out3_n,
`endif
  output logic signed [23:0] triangle,
  output logic               lock,
  output logic signed [23:0] sine1,
  output logic signed [23:0] sine2,
  output logic signed [23:0] sine3,
  output logic               out1,
  output logic               out2,
  output logic               out3
);

  localparam logic signed [23:0] TriHi = 24'(TRI_MAX);
  localparam logic signed [23:0] TriLo = -TriHi;
  localparam logic signed [23:0] Step  = 24'(TRI_STEP);
  localparam logic [PHASE_W-1:0] Off2  = PHASE_W'(21845);
  localparam logic [PHASE_W-1:0] Off3  = PHASE_W'(43691);

  // First quadrant (inclusive of 90 degrees) of round(2047*sin(2*pi*i/256)).
  localparam logic [10:0] QuarterLut [65] = '{
    11'd0,    11'd50,   11'd100,  11'd151,  11'd201,  11'd251,  11'd300,  11'd350,
    11'd399,  11'd449,  11'd497,  11'd546,  11'd594,  11'd642,  11'd690,  11'd737,
    11'd783,  11'd830,  11'd875,  11'd920,  11'd965,  11'd1009, 11'd1052, 11'd1095,
    11'd1137, 11'd1179, 11'd1219, 11'd1259, 11'd1299, 11'd1337, 11'd1375, 11'd1411,
    11'd1447, 11'd1483, 11'd1517, 11'd1550, 11'd1582, 11'd1614, 11'd1644, 11'd1674,
    11'd1702, 11'd1729, 11'd1756, 11'd1781, 11'd1805, 11'd1828, 11'd1850, 11'd1871,
    11'd1891, 11'd1910, 11'd1927, 11'd1944, 11'd1959, 11'd1973, 11'd1986, 11'd1997,
    11'd2008, 11'd2017, 11'd2025, 11'd2032, 11'd2037, 11'd2041, 11'd2045, 11'd2046,
    11'd2047
  };

  function automatic logic signed [11:0] sine_lut(input logic [7:0] idx);
    logic [10:0] mag;
    mag = idx[6] ? QuarterLut[7'd64 - {1'b0, idx[5:0]}] : QuarterLut[{1'b0, idx[5:0]}];
    return idx[7] ? -$signed({1'b0, mag}) : $signed({1'b0, mag});
  endfunction

  logic signed [23:0] tri_q, tri_d;
  logic               up_q, up_d;
  logic               lock_q, lock_d;
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic signed [23:0] sine_q [3];
  logic signed [23:0] sine_d [3];
  logic [2:0]         raw_q, raw_d;
  logic [PHASE_W-1:0] ph [3];
  logic signed [11:0] lut_s;
  logic signed [24:0] prod;

  always_comb begin
    tri_d = tri_q;
    up_d  = up_q;
    if (up_q) begin
      if (tri_q >= TriHi) begin
        tri_d = tri_q - Step;
        up_d  = 1'b0;
      end else begin
        tri_d = tri_q + Step;
      end
    end else begin
      if (tri_q <= TriLo) begin
        tri_d = tri_q + Step;
        up_d  = 1'b1;
      end else begin
        tri_d = tri_q - Step;
      end
    end
    // Registering the next-value compare keeps lock aligned with the carrier minimum.
    lock_d  = (tri_d == TriLo);
    phase_d = lock_q ? phase_q + PHASE_W'(frequency) : phase_q;
  end

  always_comb begin
    ph[0] = phase_q;
    ph[1] = phase_q + Off2;
    ph[2] = phase_q + Off3;
    lut_s = '0;
    prod  = '0;
    raw_d = '0;
    for (int n = 0; n < 3; n++) begin
      lut_s     = sine_lut(ph[n][PHASE_W-1 -: 8]);
      prod      = $signed({{13{lut_s[11]}}, lut_s}) * $signed({13'd0, amplitude});
      sine_d[n] = lock_q ? 24'(prod >>> 1) : sine_q[n];
      raw_d[n]  = sine_q[n] > tri_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tri_q   <= TriLo;
      up_q    <= 1'b1;
      lock_q  <= 1'b0;
      phase_q <= '0;
      raw_q   <= '0;
      for (int n = 0; n < 3; n++) sine_q[n] <= '0;
    end else begin
      tri_q   <= tri_d;
      up_q    <= up_d;
      lock_q  <= lock_d;
      phase_q <= phase_d;
      raw_q   <= raw_d;
      for (int n = 0; n < 3; n++) sine_q[n] <= sine_d[n];
    end
  end

  assign triangle = tri_q;
  assign lock     = lock_q;
  assign sine1    = sine_q[0];
  assign sine2    = sine_q[1];
  assign sine3    = sine_q[2];

`ifdef AC_MOTOR_DEAD_TIME_EN
  logic [2:0]  last_q, last_d, gate_q, gate_d, gate_n_q, gate_n_d;
  logic [10:0] cnt_q [3];
  logic [10:0] cnt_d [3];
  logic        busy;

  always_comb begin
    last_d   = raw_q;
    gate_d   = '0;
    gate_n_d = '0;
    busy     = 1'b0;
    for (int n = 0; n < 3; n++) begin
      cnt_d[n] = cnt_q[n];
      // Any raw edge (including one inside an active gap) restarts the both-low window.
      if (raw_q[n] != last_q[n]) begin
        busy     = (dead_time != '0);
        cnt_d[n] = busy ? dead_time - 11'd1 : '0;
      end else begin
        busy = (cnt_q[n] != '0);
        if (busy) cnt_d[n] = cnt_q[n] - 11'd1;
      end
      gate_d[n]   = raw_q[n] & ~busy;
      gate_n_d[n] = ~raw_q[n] & ~busy;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_q   <= '0;
      gate_q   <= '0;
      gate_n_q <= '0;
      // Start inside a gap so the low side cannot pulse right after reset.
      for (int n = 0; n < 3; n++) cnt_q[n] <= dead_time;
    end else begin
      last_q   <= last_d;
      gate_q   <= gate_d;
      gate_n_q <= gate_n_d;
      for (int n = 0; n < 3; n++) cnt_q[n] <= cnt_d[n];
    end
  end

  assign out1   = gate_q[0];
  assign out2   = gate_q[1];
  assign out3   = gate_q[2];
  assign out1_n = gate_n_q[0];
  assign out2_n = gate_n_q[1];
  assign out3_n = gate_n_q[2];
`else
  assign out1 = raw_q[0];
  assign out2 = raw_q[1];
  assign out3 = raw_q[2];
`endif

endmodule

// File: tb/tb_ac_motor_spwm.sv
// Directed bench for ac_motor_spwm: carrier shape, lock timing, sine loads, gate duty.
module tb_ac_motor_spwm;

  localparam longint TriMax = 4194304;
`ifdef AC_MOTOR_DEAD_TIME_EN
  localparam int Dt = 1000;
`else
  localparam int Dt = 0;
`endif

  logic               clk;
  logic               reset;
  logic        [11:0] frequency;
  logic        [11:0] amplitude;
  logic signed [23:0] triangle;
  logic               lock;
  logic signed [23:0] sine1, sine2, sine3;
  logic               out1, out2, out3;
`ifdef AC_MOTOR_DEAD_TIME_EN
  logic        [10:0] dead_time;
  logic               out1_n, out2_n, out3_n;
`endif

  ac_motor_spwm dut (
    .clk       (clk),
    .reset     (reset),
    .frequency (frequency),
    .amplitude (amplitude),
`ifdef AC_MOTOR_DEAD_TIME_EN
    .dead_time (dead_time),
    .out1_n    (out1_n),
    .out2_n    (out2_n),
    .out3_n    (out3_n),
`endif
    .triangle  (triangle),
    .lock      (lock),
    .sine1     (sine1),
    .sine2     (sine2),
    .sine3     (sine3),
    .out1      (out1),
    .out2      (out2),
    .out3      (out3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int hi1, hi2, hi3, locks;

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Independent reference: round(2047*sin), scaled by amplitude, floor-halved.
  function automatic longint exp_sine(input int ph, input int amp);
    real    v;
    longint l, p;
    v = 2047.0 * $sin(2.0 * 3.14159265358979 * real'((ph & 16'hffff) >> 8) / 256.0);
    l = (v >= 0.0) ? longint'($rtoi(v + 0.5)) : -longint'($rtoi(-v + 0.5));
    p = l * amp;
    return p >>> 1;
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    cyc++;
    hi1   += int'(out1);
    hi2   += int'(out2);
    hi3   += int'(out3);
    locks += int'(lock);
  endtask

  task automatic run_to(input int target);
    while (cyc < target) step();
  endtask

  task automatic clear_stats();
    hi1 = 0; hi2 = 0; hi3 = 0; locks = 0;
  endtask

  task automatic check_reset_vals(input string pfx);
    check({pfx, "_tri"}, triangle, -TriMax);
    check({pfx, "_lock"}, lock, 0);
    check({pfx, "_s1"}, sine1, 0);
    check({pfx, "_s2"}, sine2, 0);
    check({pfx, "_s3"}, sine3, 0);
    check({pfx, "_outs"}, {out1, out2, out3}, 0);
`ifdef AC_MOTOR_DEAD_TIME_EN
    check({pfx, "_outs_n"}, {out1_n, out2_n, out3_n}, 0);
`endif
  endtask

`ifdef AC_MOTOR_DEAD_TIME_EN
  int dt_run  = 0;
  int dt_both = 0;
  bit dt_mon  = 1'b0;
  always @(negedge clk) begin
    if (out1 && out1_n) dt_both++;
    if (!out1 && !out1_n) dt_run++;
    else begin
      if (dt_mon && dt_run != 0) check("dt_gap", dt_run, Dt);
      dt_run = 0;
    end
  end
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;
    int ph_m;
    reset     = 1'b1;
    frequency = 12'd0;
    amplitude = 12'd4095;
`ifdef AC_MOTOR_DEAD_TIME_EN
    dead_time = 11'(Dt);
`endif
    clear_stats();
    repeat (5) @(posedge clk);
    @(negedge clk);
    check_reset_vals("rst");
    reset = 1'b0;
    clear_stats();

    step();
    check("tri_step", triangle, -TriMax + 2048);
    run_to(4096);
    check("tri_peak", triangle, TriMax);
    run_to(8191);
    check("lock_early", locks, 0);
    step();
    check("tri_wrap", triangle, -TriMax);
    check("lock_hit", lock, 1);
    check("sine_pre", sine2, 0);
`ifndef AC_MOTOR_DEAD_TIME_EN
    check("out1_p1", hi1, 4095);
`endif

    step();
    check("lock_width", lock, 0);
    check("s1_load", sine1, 0);
    check("s2_load", sine2, 3646597);
    check("s3_load", sine3, -3595410);
    clear_stats();

    // Mid-period changes must wait for the next lock.
    run_to(9000);
    frequency = 12'd1234;
    amplitude = 12'd0;
    run_to(16384);
    check("lock_p2", lock, 1);
    check("lock_count", locks, 1);
    check("sine_hold", sine2, 3646597);
    step();
    check("amp0_s1", sine1, 0);
    check("amp0_s2", sine2, 0);
    check("amp0_s3", sine3, 0);
    check("out1_p2", hi1, 4095 - Dt);
`ifndef AC_MOTOR_DEAD_TIME_EN
    check("out2_p2", hi2, 7657);
    check("out3_p2", hi3, 585);
`endif
`ifdef AC_MOTOR_DEAD_TIME_EN
    dt_mon = 1'b1;
`endif
    clear_stats();

    run_to(17000);
    frequency = 12'd2047;
    amplitude = 12'd4095;
    run_to(24576);
    check("lock_p3", lock, 1);
    step();
    check("out1_p3", hi1, 4095 - Dt);
`ifndef AC_MOTOR_DEAD_TIME_EN
    check("out2_p3", hi2, 4095);
    check("out3_p3", hi3, 4095);
`endif
    ph_m = 1234;
    for (int k = 0; k < 3; k++) begin
      if (k != 0) begin
        run_to(24576 + 8192 * k);
        check("lock_f", lock, 1);
        step();
      end
      check("f_s1", sine1, exp_sine(ph_m, 4095));
      check("f_s2", sine2, exp_sine(ph_m + 21845, 4095));
      check("f_s3", sine3, exp_sine(ph_m + 43691, 4095));
      ph_m += 2047;
    end

`ifdef AC_MOTOR_DEAD_TIME_EN
    dt_mon = 1'b0;
`endif
    run_to(43000);
    reset = 1'b1;
    step();
    check_reset_vals("mid");
    step();
    reset = 1'b0;
    base  = cyc;
    step();
    check("tri_step2", triangle, -TriMax + 2048);
    run_to(base + 8192);
    check("lock_again", lock, 1);
    step();
    check("phase_rst_s2", sine2, 3646597);
    check("phase_rst_s3", sine3, -3595410);

`ifdef AC_MOTOR_DEAD_TIME_EN
    check("dt_overlap", dt_both, 0);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ac_motor_spwm.md
# ac_motor_spwm

Three-phase sinusoidal PWM generator for the AC motor inverter path. It contains three parts:
- a symmetric 24-bit triangle carrier;
- a regularly-sampled three-phase sine reference generator, scaled by frequency and amplitude words;
- three comparators that produce the phase gate signals.

The carrier, references and sample-lock strobe are exported as observation ports. Gate outputs drive the downstream power-stage logic.

## Interface
Parameters:
- TRI_STEP, 2048: carrier increment per clock.
- TRI_MAX, 4194304 (2^22): carrier peak magnitude; TRI_MAX/TRI_STEP must be an integer.
- PHASE_W, 16: phase accumulator width.

Ports:
- clk  in  1  rising-edge clock; one clock domain. Reset is synchronous and active-high.
- reset  in  1  synchronous, active-high.
- frequency  in  12 unsigned  phase increment per carrier period.
- amplitude  in  12 unsigned  reference scale.
- triangle  out  24 signed  carrier.
- lock  out  1  one-cycle strobe at carrier minimum.
- sine1, sine2, sine3  out  24 signed  phase references.
- out1, out2, out3  out  1  PWM gate outputs.
- dead_time  in  11 unsigned  present only with AC_MOTOR_DEAD_TIME_EN.
- out1_n, out2_n, out3_n  out  1  complementary gates, present only with AC_MOTOR_DEAD_TIME_EN.

## Operation
Carrier:
- Register ramps up from -TRI_MAX by +TRI_STEP per clock to +TRI_MAX, then down by TRI_STEP to -TRI_MAX, and repeats.
- Each extreme is held for exactly one cycle.
- Default period is 8192 clocks.

Lock:
- Registered; high exactly in the cycles where triangle == -TRI_MAX.
- Excluded: the cycle immediately after reset.

Sine generator:
- A 256-entry LUT holds lut[i] = round(2047*sin(2*pi*i/256)) as 12-bit signed values.
- A PHASE_W-bit accumulator phase, wrapping modulo 2^PHASE_W, provides phase offsets p1 = phase, p2 = phase+21845 and p3 = phase+43691.
- LUT index for each phase = top 8 bits of its offset.
- On every clock edge where lock==1:
  - sineN <= (lut[idx(pN)] * amplitude) >>> 1, using a signed multiply and an arithmetic shift (floor);
  - phase <= phase + frequency.
- Current (pre-increment) phase is used for the load; frequency and amplitude are sampled only on that edge.
- Sines hold constant between lock strobes. Magnitude is at most 4191232, which is below TRI_MAX, so there is no overmodulation.

Comparators:
- outN <= (sineN > triangle), a strict signed compare, registered.
- Equality gives 0.

## Timing
- Reset values: triangle = -TRI_MAX (direction up); lock = 0; phase = 0; sine1..3 = 0; out1..3 = 0; out*_n = 0.
- The carrier steps the cycle after reset deasserts. The first lock occurs 8192 clocks after release.
- Sine latency: new value is visible 1 cycle after the lock-high cycle.
- Gate latency: 1 cycle after the triangle/sine values it compares.
- Frequency and amplitude changes take effect at the next lock only; no mid-period glitch.
- Reset asserted mid-operation returns everything to reset values on that edge, regardless of carrier position.

## Configuration
AC_MOTOR_DEAD_TIME_EN:
- Defined:
  - dead_time and out1_n..out3_n exist.
  - Each outN/outN_n pair is derived from the raw comparator bit.
  - On every raw transition both outputs are 0 for dead_time clocks, then the newly active side goes high.
  - A raw transition during dead time restarts the count.
  - dead_time = 0 gives plain complementary outputs.
  - Outputs are never both 1.
- Undefined: ports are absent and outN is the raw comparator register.

## Test plan
- Reset held 5 cycles, then released -> all outputs at reset values; triangle = -4194304, then -4192256 on the next cycle.
- Free run, frequency=0, amplitude=4095 -> triangle peaks at +4194304 at 4096 clocks and returns to -4194304 at 8192 clocks; lock period 8192, width 1.
- Same stimulus -> after first lock sine1=0 and sine2=3646597; out1 high 4095 of every 8192 cycles.
- amplitude=0, any frequency -> all sines 0; all three outs high 4095/8192 cycles.
- frequency=2047 -> phase advances 2047 per lock; sine1 follows lut[(2047k)>>8]*4095>>>1; sine2 lags sine3 by 1/3 cycle.
- AC_MOTOR_DEAD_TIME_EN, dead_time=1000 -> 1000-cycle both-low gap at every edge; out1 & out1_n never both 1.
